// File: rtl/sgdma_rd_engine.sv
// sgdma_rd_engine
//   Read engine of the scatter-gather DMA channel. A single descriptor
//   command (source address + byte count) is cut into AXI INCR read bursts.
//   Burst length is bounded by the remaining beats and MAX_BEATS. When the
//   macro SGDMA_RD_4K_SPLIT_EN is defined, bursts also never cross a 4 KB
//   boundary. FIFO space is reserved per burst before the AR is issued, so
//   returned beats are written to the channel FIFO unconditionally.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   start_i, cmd_i       command strobe; cmd = {src addr[31:0], bytes[15:0]}
//   done_o, err_o        engine idle, sticky read error
//   ar*_o / arready_i    AXI read address channel
//   r*_i / rready_o      AXI read data channel
//   fifo_free_i          free entries in the downstream FIFO
//   fifo_wren_o/wdata_o  FIFO write port (combinational with the R handshake)
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Once arvalid_o is high, arvalid_o/araddr_o/arlen_o stay
// stable until arready_i is seen.
module sgdma_rd_engine #(
   parameter int DATA_W     = 32,
   parameter int MAX_BEATS  = 16,
   parameter int FIFO_DEPTH = 64,
   parameter int MAX_OUTST  = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start_i,
   input  logic [47:0]                   cmd_i,
   output logic                          done_o,
   output logic                          err_o,
   output logic [31:0]                   araddr_o,
   output logic [3:0]                    arlen_o,
   output logic [2:0]                    arsize_o,
   output logic [1:0]                    arburst_o,
   output logic                          arvalid_o,
   input  logic                          arready_i,
   input  logic [DATA_W-1:0]             rdata_i,
   input  logic [1:0]                    rresp_i,
   input  logic                          rlast_i,
   input  logic                          rvalid_i,
   output logic                          rready_o,
   input  logic [$clog2(FIFO_DEPTH):0]   fifo_free_i,
   output logic                          fifo_wren_o,
   output logic [DATA_W-1:0]             fifo_wdata_o
);

   localparam int BPB = DATA_W / 8;
   localparam int SZ  = $clog2(BPB);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ADDR  = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;     // address of the next burst
   logic [15:0] beats_q, beats_d;   // beats not yet requested
   logic [15:0] pend_q, pend_d;     // beats requested but not yet written
   logic [2:0]  outst_q, outst_d;   // bursts requested, rlast not yet seen
   logic        err_q, err_d;
   logic        hold_q, hold_d;     // AR presented but not yet accepted

   logic [15:0] len_base;
   logic [15:0] len;
   logic        can_issue;
   logic        ar_hs;
   logic        r_hs;
   logic        rlast_hs;

`ifdef SGDMA_RD_4K_SPLIT_EN
   logic [12:0] room;               // beats left before the next 4 KB line
`endif

   // Length of the burst at addr_q.
   always_comb begin
      len_base = (beats_q > 16'(MAX_BEATS)) ? 16'(MAX_BEATS) : beats_q;
`ifdef SGDMA_RD_4K_SPLIT_EN
      room = (13'h1000 - {1'b0, addr_q[11:0]}) >> SZ;
      len  = (16'(room) < len_base) ? 16'(room) : len_base;
`else
      len  = len_base;
`endif
   end

   // Issue rule: room for every beat already in flight plus this burst.
   // A pending AR (hold_q) is never retracted, even after an error.
   assign can_issue = (state_q == S_ADDR) && !err_q &&
                      (outst_q < 3'(MAX_OUTST)) &&
                      (17'(fifo_free_i) >= (17'(pend_q) + 17'(len)));

   assign arvalid_o    = (state_q == S_ADDR) && (hold_q || can_issue);
   assign araddr_o     = addr_q;
   assign arlen_o      = (state_q == S_ADDR) ? 4'(len - 16'd1) : 4'd0;
   assign arsize_o     = 3'(SZ);
   assign arburst_o    = 2'b01;
   assign rready_o     = (outst_q != 3'd0);
   assign fifo_wren_o  = r_hs;
   assign fifo_wdata_o = rdata_i;
   assign done_o       = (state_q == S_IDLE);
   assign err_o        = err_q;

   assign ar_hs    = arvalid_o & arready_i;
   assign r_hs     = rvalid_i & rready_o;
   assign rlast_hs = r_hs & rlast_i;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      beats_d = beats_q;
      err_d   = err_q;
      hold_d  = arvalid_o & ~arready_i;
      pend_d  = pend_q + (ar_hs ? len : 16'd0) - {15'd0, r_hs};
      outst_d = outst_q + {2'd0, ar_hs} - {2'd0, rlast_hs};

      if (r_hs && (rresp_i != 2'b00)) begin
         err_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               addr_d  = cmd_i[47:16];
               beats_d = 16'(cmd_i[15:0] >> SZ);
               err_d   = 1'b0;
               state_d = (beats_d == 16'd0) ? S_DRAIN : S_ADDR;
            end
         end
         S_ADDR: begin
            if (ar_hs) begin
               addr_d  = addr_q + (32'(len) << SZ);
               beats_d = beats_q - len;
               if ((beats_d == 16'd0) || err_q) begin
                  state_d = S_DRAIN;
               end
            end else if (err_q && !hold_q) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Use the next-state count so done_o rises right after the final rlast.
            if (outst_d == 3'd0) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= 32'd0;
         beats_q <= 16'd0;
         pend_q  <= 16'd0;
         outst_q <= 3'd0;
         err_q   <= 1'b0;
         hold_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         beats_q <= beats_d;
         pend_q  <= pend_d;
         outst_q <= outst_d;
         err_q   <= err_d;
         hold_q  <= hold_d;
      end
   end

endmodule

// File: tb/tb_sgdma_rd_engine.sv
module tb_sgdma_rd_engine;

   localparam int DATA_W     = 32;
   localparam int MAX_BEATS  = 16;
   localparam int FIFO_DEPTH = 64;
   localparam int MAX_OUTST  = 2;
   localparam int FW         = $clog2(FIFO_DEPTH) + 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic                start_i;
   logic [47:0]         cmd_i;
   logic                done_o, err_o;
   logic [31:0]         araddr_o;
   logic [3:0]          arlen_o;
   logic [2:0]          arsize_o;
   logic [1:0]          arburst_o;
   logic                arvalid_o, arready_i;
   logic [DATA_W-1:0]   rdata_i;
   logic [1:0]          rresp_i;
   logic                rlast_i, rvalid_i, rready_o;
   logic [FW-1:0]       fifo_free_i;
   logic                fifo_wren_o;
   logic [DATA_W-1:0]   fifo_wdata_o;

   sgdma_rd_engine #(
      .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS),
      .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTST(MAX_OUTST)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .cmd_i(cmd_i),
      .done_o(done_o), .err_o(err_o),
      .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
      .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
      .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
      .rvalid_i(rvalid_i), .rready_o(rready_o),
      .fifo_free_i(fifo_free_i), .fifo_wren_o(fifo_wren_o),
      .fifo_wdata_o(fifo_wdata_o)
   );

   // ---------------- checking ----------------
   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- slave model config (written by main only) ----------------
   bit arready_en  = 1'b1;
   bit free_ovr_en = 1'b0;
   int free_ovr    = 0;
   int r_delay_cfg = 0;
   int err_idx     = -1;

   // ---------------- slave model logs (written by slave only) ----------------
   logic [31:0]       ar_addr_log[$];
   int                ar_len_log[$];
   int                ar_cyc_log[$];
   int                rlast_cyc_log[$];
   logic [DATA_W-1:0] got_q[$];
   int                burst_q[$];
   int                cyc = 0;
   int                beat_idx = 0;
   int                beat_in_burst = 0;
   int                tx_writes = 0;
   int                r_hold = 0;
   int                done_rise_cyc = 0;
   bit                done_prev = 1'b1;

   // AXI read slave + FIFO free-count model. Drives on the falling edge,
   // samples 1 ns later so the upcoming rising edge sees the logged state.
   initial begin
      arready_i   = 1'b0;
      rvalid_i    = 1'b0;
      rlast_i     = 1'b0;
      rresp_i     = 2'b00;
      rdata_i     = '0;
      fifo_free_i = FW'(FIFO_DEPTH);
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            burst_q.delete();
            beat_in_burst = 0;
            tx_writes     = 0;
            arready_i     = 1'b0;
            rvalid_i      = 1'b0;
            rlast_i       = 1'b0;
            rresp_i       = 2'b00;
            fifo_free_i   = FW'(FIFO_DEPTH);
         end else begin
            fifo_free_i = free_ovr_en ? FW'(free_ovr) : FW'(FIFO_DEPTH - tx_writes);
            arready_i   = arready_en;
            if (burst_q.size() > 0 && r_hold == 0) begin
               rvalid_i = 1'b1;
               rdata_i  = 32'hA500_0000 + 32'(beat_idx);
               rlast_i  = (beat_in_burst == burst_q[0] - 1);
               rresp_i  = (beat_idx == err_idx) ? 2'b10 : 2'b00;
            end else begin
               rvalid_i = 1'b0;
               rlast_i  = 1'b0;
               rresp_i  = 2'b00;
               if (burst_q.size() > 0 && r_hold > 0) r_hold--;
            end
         end
         #1;
         if (rst_n) begin
            if (start_i) begin
               r_hold    = r_delay_cfg;
               tx_writes = 0;
            end
            if (arvalid_o && arready_i) begin
               ar_addr_log.push_back(araddr_o);
               ar_len_log.push_back(int'(arlen_o));
               ar_cyc_log.push_back(cyc);
               burst_q.push_back(int'(arlen_o) + 1);
            end
            if (fifo_wren_o) begin
               got_q.push_back(fifo_wdata_o);
               beat_idx++;
               tx_writes++;
               if (rlast_i) begin
                  rlast_cyc_log.push_back(cyc);
                  void'(burst_q.pop_front());
                  beat_in_burst = 0;
               end else begin
                  beat_in_burst++;
               end
            end
            if (done_o && !done_prev) done_rise_cyc = cyc;
            done_prev = done_o;
         end
      end
   end

   // ---------------- driver tasks ----------------
   logic [DATA_W-1:0] exp_q[$];

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic start_cmd(input logic [31:0] addr, input logic [15:0] bytes);
      cmd_i   = {addr, bytes};
      start_i = 1'b1;
      step();
      start_i = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         if (done_o) break;
         step();
      end
      check_eq(tag, 32'(done_o), 32'd1);
   endtask

   // Scoreboard: beat k of the whole run carries 0xA5000000 + k.
   task automatic check_data(input string tag, input int base, input int n);
      int mism;
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(32'hA500_0000 + 32'(base + i));
      check_eq(tag, 32'(got_q.size() - base), 32'(n));
      mism = 0;
      for (int i = 0; i < n; i++) begin
         if (base + i >= got_q.size() || got_q[base + i] !== exp_q[i]) mism++;
      end
      check_eq({tag, "_data"}, 32'(mism), 32'd0);
   endtask

   // ---------------- directed tests ----------------
   int ab, wb, rb;

   initial begin
      rst_n   = 1'b0;
      start_i = 1'b0;
      cmd_i   = '0;
      repeat (3) step();

      // Reset values
      check_eq("rst_done", 32'(done_o), 32'd1);
      check_eq("rst_err", 32'(err_o), 32'd0);
      check_eq("rst_arvalid", 32'(arvalid_o), 32'd0);
      check_eq("rst_rready", 32'(rready_o), 32'd0);
      check_eq("rst_wren", 32'(fifo_wren_o), 32'd0);
      check_eq("rst_araddr", araddr_o, 32'd0);
      check_eq("rst_arlen", 32'(arlen_o), 32'd0);
      check_eq("arsize", 32'(arsize_o), 32'd2);
      check_eq("arburst", 32'(arburst_o), 32'd1);
      rst_n = 1'b1;
      step();

      // 200 bytes at 0x1000: 50 beats as 16/16/16/2
      ab = ar_addr_log.size(); wb = got_q.size(); rb = rlast_cyc_log.size();
      start_cmd(32'h0000_1000, 16'd200);
      check_eq("t2_done_fall", 32'(done_o), 32'd0);
      wait_done("t2_done", 500);
      check_eq("t2_ar_cnt", 32'(ar_addr_log.size() - ab), 32'd4);
      if (ar_addr_log.size() - ab == 4) begin
         check_eq("t2_ar0_addr", ar_addr_log[ab+0], 32'h1000);
         check_eq("t2_ar1_addr", ar_addr_log[ab+1], 32'h1040);
         check_eq("t2_ar2_addr", ar_addr_log[ab+2], 32'h1080);
         check_eq("t2_ar3_addr", ar_addr_log[ab+3], 32'h10C0);
         check_eq("t2_ar0_len", 32'(ar_len_log[ab+0]), 32'd15);
         check_eq("t2_ar2_len", 32'(ar_len_log[ab+2]), 32'd15);
         check_eq("t2_ar3_len", 32'(ar_len_log[ab+3]), 32'd1);
      end
      check_data("t2_wr", wb, 50);
      if (rlast_cyc_log.size() > rb)
         check_eq("t2_done_lat", 32'(done_rise_cyc - rlast_cyc_log[rlast_cyc_log.size()-1]), 32'd1);
      check_eq("t2_err", 32'(err_o), 32'd0);

      // 64 bytes at 0x0FF0: split at 4 KB only when enabled
      ab = ar_addr_log.size(); wb = got_q.size();
      start_cmd(32'h0000_0FF0, 16'd64);
      wait_done("t3_done", 300);
`ifdef SGDMA_RD_4K_SPLIT_EN
      check_eq("t3_ar_cnt", 32'(ar_addr_log.size() - ab), 32'd2);
      if (ar_addr_log.size() - ab == 2) begin
         check_eq("t3_ar0_addr", ar_addr_log[ab+0], 32'h0FF0);
         check_eq("t3_ar0_len", 32'(ar_len_log[ab+0]), 32'd3);
         check_eq("t3_ar1_addr", ar_addr_log[ab+1], 32'h1000);
         check_eq("t3_ar1_len", 32'(ar_len_log[ab+1]), 32'd11);
      end
`else
      check_eq("t3_ar_cnt", 32'(ar_addr_log.size() - ab), 32'd1);
      if (ar_addr_log.size() - ab == 1) begin
         check_eq("t3_ar0_addr", ar_addr_log[ab+0], 32'h0FF0);
         check_eq("t3_ar0_len", 32'(ar_len_log[ab+0]), 32'd15);
      end
`endif
      check_data("t3_wr", wb, 16);

      // FIFO space gating: 16-beat burst, only 10 free
      ab = ar_addr_log.size(); wb = got_q.size();
      free_ovr_en = 1'b1; free_ovr = 10; arready_en = 1'b0;
      start_cmd(32'h0000_2000, 16'd64);
      repeat (8) step();
      check_eq("t4_blocked", 32'(arvalid_o), 32'd0);
      free_ovr = 16;
      step();
      check_eq("t4_arvalid", 32'(arvalid_o), 32'd1);
      check_eq("t4_araddr", araddr_o, 32'h2000);
      check_eq("t4_arlen", 32'(arlen_o), 32'd15);
      repeat (3) step();
      check_eq("t4_hold", 32'(arvalid_o), 32'd1);
      arready_en = 1'b1; free_ovr_en = 1'b0;
      wait_done("t4_done", 300);
      check_eq("t4_ar_cnt", 32'(ar_addr_log.size() - ab), 32'd1);
      check_data("t4_wr", wb, 16);

      // Outstanding limit: first R beat delayed
      ab = ar_addr_log.size(); wb = got_q.size(); rb = rlast_cyc_log.size();
      r_delay_cfg = 20;
      start_cmd(32'h0000_3000, 16'd256);
      repeat (15) step();
      check_eq("t5_ar_cnt_early", 32'(ar_addr_log.size() - ab), 32'd2);
      check_eq("t5_arvalid_blk", 32'(arvalid_o), 32'd0);
      wait_done("t5_done", 500);
      r_delay_cfg = 0;
      check_eq("t5_ar_cnt", 32'(ar_addr_log.size() - ab), 32'd4);
      if (ar_addr_log.size() - ab >= 3 && rlast_cyc_log.size() > rb)
         check_eq("t5_ar2_after_rlast", 32'(ar_cyc_log[ab+2] - rlast_cyc_log[rb]), 32'd1);
      check_data("t5_wr", wb, 64);

      // Read error on beat 3 of burst 0: only the two issued bursts complete
      ab = ar_addr_log.size(); wb = got_q.size();
      err_idx = beat_idx + 3;
      start_cmd(32'h0000_4000, 16'd256);
      wait_done("t6_done", 500);
      err_idx = -1;
      check_eq("t6_err", 32'(err_o), 32'd1);
      check_eq("t6_ar_cnt", 32'(ar_addr_log.size() - ab), 32'd2);
      check_data("t6_wr", wb, 32);

      // Start clears err; reset mid-burst; new command afterwards
      start_cmd(32'h0000_5000, 16'd200);
      check_eq("t7_err_clr", 32'(err_o), 32'd0);
      repeat (5) step();
      rst_n = 1'b0;
      step();
      check_eq("t7_rst_done", 32'(done_o), 32'd1);
      check_eq("t7_rst_arvalid", 32'(arvalid_o), 32'd0);
      check_eq("t7_rst_rready", 32'(rready_o), 32'd0);
      check_eq("t7_rst_wren", 32'(fifo_wren_o), 32'd0);
      check_eq("t7_rst_araddr", araddr_o, 32'd0);
      check_eq("t7_rst_arlen", 32'(arlen_o), 32'd0);
      rst_n = 1'b1;
      step();
      ab = ar_addr_log.size(); wb = got_q.size();
      start_cmd(32'h0000_6000, 16'd32);
      wait_done("t7_done", 200);
      check_eq("t7_ar_cnt", 32'(ar_addr_log.size() - ab), 32'd1);
      if (ar_addr_log.size() - ab == 1) begin
         check_eq("t7_ar_addr", ar_addr_log[ab], 32'h6000);
         check_eq("t7_ar_len", 32'(ar_len_log[ab]), 32'd7);
      end
      check_data("t7_wr", wb, 8);

      // Byte count below one beat: done low for exactly one cycle, no AR
      ab = ar_addr_log.size();
      start_cmd(32'h0000_7000, 16'd3);
      check_eq("t8_done_low", 32'(done_o), 32'd0);
      step();
      check_eq("t8_done_back", 32'(done_o), 32'd1);
      check_eq("t8_ar_cnt", 32'(ar_addr_log.size() - ab), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
